tmds_lane_sequencer: RTL
========================

# tmds_lane_sequencer

Word-rate controller for one TMDS/ODDR serial lane, running entirely in the 5x serial clock domain. It generates the mod-5 word phase and sequences the lane through a power-up link sequence: off, quiet idle symbols, training symbols, then live data. It takes 10-bit words from an upstream source over a valid/ready handshake and emits one DDR bit pair per clock for direct connection to the lane's ODDR primitive. On source underrun it substitutes a control symbol and counts the event.

## Interface
- QUIET_WORDS, 16, number of IDLE_WORD symbols sent after enable (0..65535; 0 skips QUIET)
- TRAIN_WORDS, 64, number of TRAIN_WORD symbols sent before RUN (0..65535; 0 skips TRAIN)
- IDLE_WORD, 10'b1101010100, quiet and underrun fill symbol (TMDS control 00)
- TRAIN_WORD, 10'b1111100000, training symbol
- serialclk  in  1  5x serial clock, sole clock
- rstn  in  1  reset, synchronous, active-low
- enable  in  1  lane enable, sampled only at word boundaries
- pdata  in  10  parallel word from source
- pvalid  in  1  pdata valid
- pready  out  1  word accepted this cycle when pvalid=1 (combinational)
- dout_h  out  1  ODDR rising-edge bit (even bit of current word)
- dout_l  out  1  ODDR falling-edge bit (odd bit of current word)
- load  out  1  word-boundary strobe, high during phase 4
- state  out  2  0=OFF, 1=QUIET, 2=TRAIN, 3=RUN
- underrun_cnt  out  16  saturating underrun counter

## Operation
- Phase counter 0..4, increments every cycle and wraps 4->0; it never stops, in any state.
- Each word is loaded into two 5-bit shift registers at the clock edge ending phase 4. In phase k of the following 5 cycles: dout_h=word[2k], dout_l=word[2k+1].
- All state and word decisions happen only at the phase-4 edge (the boundary); enable is sampled only there.
- Word counter (16-bit) counts the words loaded in the current state. Entering a state loads that state's first word and sets the counter to 1.
- Transitions at the boundary, in priority order:
  - enable=0, any state -> OFF; load 10'h000.
  - OFF, enable=1 -> QUIET, load IDLE_WORD. If QUIET_WORDS=0, go to TRAIN instead; if TRAIN_WORDS is also 0, go to RUN.
  - QUIET, cnt<QUIET_WORDS -> load IDLE_WORD, cnt+1. When cnt=QUIET_WORDS -> TRAIN, load TRAIN_WORD (or RUN if TRAIN_WORDS=0).
  - TRAIN, cnt<TRAIN_WORDS -> load TRAIN_WORD, cnt+1. When cnt=TRAIN_WORDS -> RUN.
  - RUN -> if pvalid, load pdata; otherwise load IDLE_WORD and increment underrun_cnt, saturating at 16'hFFFF.
- pready = (phase==4) && (next state is RUN). It is never high in other phases, and never high when enable=0.
- A handshake completes only when pvalid && pready. pdata is captured at that edge. pvalid may stay high across phases without effect.
- underrun_cnt is cleared only by reset. It does not change outside RUN boundaries.

## Timing
- Reset (rstn=0 at an edge): phase=0, state=OFF, cnt=0, both shift registers=0, dout_h=dout_l=0, underrun_cnt=0.
  - load=0 and pready=0 while rstn=0.
- First boundary after reset release: phase 4 occurs in the 5th cycle after the release edge.
- Reset mid-word aborts the word immediately; the next cycle's dout is 0.
- Latency: a word accepted at a phase-4 edge drives dout starting the next cycle (phase 0) and holds the lane for exactly 5 cycles.
- state changes at the same edge that loads the new state's first word.
- enable deassertion never truncates a word. The current word completes, then zeros follow.
- Lane throughput in RUN is exactly 1 word per 5 cycles; no back-to-back acceptance is possible.

## Test plan
- Reset: hold rstn=0 for 3 cycles, then release with enable=0. Required: all outputs 0, state=0, load high every 5th cycle starting at cycle 5, pready never high.
- Startup with QUIET_WORDS=2 and TRAIN_WORDS=3, enable=1 from reset release. Required: word sequence IDLE, IDLE, TRAIN, TRAIN, TRAIN, then the first pdata. state goes 1,2,3 at boundaries 1, 3 and 6. pready is first high at boundary 6.
- Bit order in RUN with pdata=10'h2A5 accepted. Required: (dout_h,dout_l) over 5 cycles = (1,0), (1,0), (0,1), (0,1), (0,1).
- Underrun in RUN: hold pvalid=0 for 3 boundaries. Required: 3 IDLE_WORD symbols on the lane, underrun_cnt 0->3. Preload to 16'hFFFE and underrun 3 more times; required: counter stops at 16'hFFFF.
- enable dropped in phase 2 of a data word: the word completes all 5 bits, the next word is 10'h000, state=0, and pready stays low.
- rstn asserted in phase 3 of a RUN word: the next cycle gives dout=0, state=0 and underrun_cnt=0. After release, the full QUIET/TRAIN sequence repeats.

Source files
------------

// File: rtl/tmds_lane_sequencer.sv
// Word-rate controller for one TMDS/ODDR lane in the 5x serial clock domain.
// Sequences OFF -> QUIET -> TRAIN -> RUN and serialises words as DDR bit pairs.
`timescale 1ns/1ps
module tmds_lane_sequencer #(
    parameter int unsigned QUIET_WORDS = 16,
    parameter int unsigned TRAIN_WORDS = 64,
    parameter logic [9:0]  IDLE_WORD   = 10'b1101010100,
    parameter logic [9:0]  TRAIN_WORD  = 10'b1111100000
) (
    input  logic        serialclk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [9:0]  pdata,
    input  logic        pvalid,
    output logic        pready,
    output logic        dout_h,
    output logic        dout_l,
    output logic        load,
    output logic [1:0]  state,
    output logic [15:0] underrun_cnt
);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        QUIET = 2'd1,
        TRAIN = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [15:0] QW = 16'(QUIET_WORDS);
    localparam logic [15:0] TW = 16'(TRAIN_WORDS);

    state_t      st_q;
    state_t      st_d;
    logic [2:0]  phase_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] ucnt_q;
    logic [4:0]  sh_h;
    logic [4:0]  sh_l;
    logic [9:0]  word_d;
    logic        boundary;
    logic        underrun;

    assign boundary = (phase_q == 3'd4);

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        if (!enable) begin
            st_d  = OFF;
            cnt_d = '0;
        end else begin
            unique case (st_q)
                OFF: begin
                    st_d  = (QW != 16'd0) ? QUIET :
                            (TW != 16'd0) ? TRAIN : RUN;
                    cnt_d = 16'd1;
                end
                QUIET: begin
                    if (cnt_q < QW) begin
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        st_d  = (TW != 16'd0) ? TRAIN : RUN;
                        cnt_d = 16'd1;
                    end
                end
                TRAIN: begin
                    if (cnt_q < TW) begin
                        cnt_d = cnt_q + 16'd1;
                    end else begin
                        st_d  = RUN;
                        cnt_d = 16'd1;
                    end
                end
                RUN: begin
                    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                end
            endcase
        end
    end

    // The word is chosen by the state being entered, so the first word
    // of a new state goes out on the same edge as the state change.
    always_comb begin
        word_d = '0;
        unique case (st_d)
            OFF:   word_d = '0;
            QUIET: word_d = IDLE_WORD;
            TRAIN: word_d = TRAIN_WORD;
            RUN:   word_d = pvalid ? pdata : IDLE_WORD;
        endcase
    end

    assign underrun = (st_d == RUN) && !pvalid;

    always_ff @(posedge serialclk) begin
        if (!rstn) begin
            phase_q <= '0;
            st_q    <= OFF;
            cnt_q   <= '0;
            ucnt_q  <= '0;
            sh_h    <= '0;
            sh_l    <= '0;
        end else begin
            phase_q <= boundary ? 3'd0 : phase_q + 3'd1;
            if (boundary) begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                sh_h  <= {word_d[8], word_d[6], word_d[4],
                          word_d[2], word_d[0]};
                sh_l  <= {word_d[9], word_d[7], word_d[5],
                          word_d[3], word_d[1]};
                if (underrun && ucnt_q != 16'hFFFF) begin
                    ucnt_q <= ucnt_q + 16'd1;
                end
            end else begin
                sh_h <= {1'b0, sh_h[4:1]};
                sh_l <= {1'b0, sh_l[4:1]};
            end
        end
    end

    assign dout_h       = sh_h[0];
    assign dout_l       = sh_l[0];
    assign load         = rstn && boundary;
    assign pready       = rstn && boundary && (st_d == RUN);
    assign state        = st_q;
    assign underrun_cnt = ucnt_q;

endmodule
